// File: rtl/skid_pkg.sv
// Shared types and constants for the two-entry valid/ready skid buffer.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/dff.sv
// Plain D flip-flop bank with synchronous active-high reset to zero.
module dff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: registered in_ready breaks the
// combinational ready path while still sustaining one transfer per cycle.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("skid_buffer: WIDTH out of range");
  end

  logic [1:0]       state_q;
  state_t           next_state;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  // Loads only happen on an accepted word, so X on in_data while idle never lands.
  always_comb begin
    next_state    = EMPTY;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          load_out   = 1'b1;
          next_state = BUSY;
        end else begin
          next_state = EMPTY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          load_out   = 1'b1;
          next_state = BUSY;
        end else if (in_valid) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (out_ready) begin
          next_state = EMPTY;
        end else begin
          next_state = BUSY;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          next_state    = BUSY;
        end else begin
          next_state = FULL;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  assign out_d  = load_out  ? (out_from_skid ? skid_q : in_data) : out_q;
  assign skid_d = load_skid ? in_data : skid_q;

  dff #(.WIDTH(2)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (next_state),
    .q     (state_q)
  );

  dff #(.WIDTH(WIDTH)) u_out_reg (
    .clk   (clk),
    .reset (reset),
    .d     (out_d),
    .q     (out_q)
  );

  dff #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .d     (skid_d),
    .q     (skid_q)
  );

  // Status flags are decoded from next_state so they are true flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= OCC_EMPTY;
    end else begin
      out_valid <= (next_state != EMPTY);
      in_ready  <= (next_state != FULL);
      case (next_state)
        BUSY:    count <= OCC_BUSY;
        FULL:    count <= OCC_FULL;
        default: count <= OCC_EMPTY;
      endcase
    end
  end

  assign out_data = out_q;

endmodule
